nvdla_dmaif_wr_nport: RTL and testbench

Parametrised write-DMA router between one engine-side write request stream and NUM_IF memory interfaces (MCIF, CVIF, further ports).
- Steers each request beat to the interface chosen by the destination-RAM register.
- Records which interface owes an ack for every ack-requesting command in an ordered ID FIFO.
- Returns completions to the engine strictly in issue order, even when interfaces complete out of order relative to each other.

---
 rtl/nvdla_dmaif_wr_nport_pkg.sv | 19 +
 rtl/nvdla_dmaif_skid2.sv | 53 +++++
 rtl/nvdla_dmaif_wr_nport.sv | 159 +++++++++++++++
 tb/tb_nvdla_dmaif_wr_nport.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvdla_dmaif_wr_nport_pkg.sv
// Shared constants and helpers for the write-DMA interface router.
// Payload field positions, interface indices and a constant clog2.
package nvdla_dmaif_wr_nport_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int DEF_PD_W     = 515;
  localparam int CMD_FLAG_BIT = DEF_PD_W - 1;
  localparam int ACK_BIT      = 77;

  localparam int IF_CVIF = 0;
  localparam int IF_MCIF = 1;

endpackage

// File: rtl/nvdla_dmaif_skid2.sv
// Two-entry skid buffer with registered outputs and full throughput.
// o_ready depends only on internal state, never on i_valid.
module nvdla_dmaif_skid2
  import nvdla_dmaif_wr_nport_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_out_vld;
  logic         r_skid_vld;
  logic [W-1:0] r_out_data;
  logic [W-1:0] r_skid_data;
  logic         w_push;
  logic         w_load;

  assign o_ready = !r_skid_vld;
  assign w_push  = i_valid & !r_skid_vld;
  // The output register may be refilled when it is empty or being drained.
  assign w_load  = !r_out_vld | i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_load) begin
      r_out_vld  <= r_skid_vld | w_push;
      r_skid_vld <= 1'b0;
    end else if (w_push) begin
      r_skid_vld <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_load) begin
      r_out_data <= r_skid_vld ? r_skid_data : i_data;
    end else if (w_push) begin
      r_skid_data <= i_data;
    end
  end

  assign o_valid = r_out_vld;
  assign o_data  = r_out_data;

endmodule

// File: rtl/nvdla_dmaif_wr_nport.sv
// Write-DMA router: steers engine beats to NUM_IF interfaces and returns acks in issue order.
// Optional NVDLA_DMAIF_WR_ERR_CHK_EN adds a sticky dmaif_wr_err for unexpected completions.
module nvdla_dmaif_wr_nport
  import nvdla_dmaif_wr_nport_pkg::*;
#(
  parameter  int NUM_IF    = 2,
  parameter  int PD_W      = DEF_PD_W,
  parameter  int ACK_BIT   = nvdla_dmaif_wr_nport_pkg::ACK_BIT,
  parameter  int ACK_DEPTH = 8,
  localparam int SEL_W     = (clog2(NUM_IF) > 1) ? clog2(NUM_IF) : 1,
  localparam int CNT_W     = clog2(ACK_DEPTH + 1)
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic [SEL_W-1:0]       reg2dp_dst_ram_type,
  input  logic [PD_W-1:0]        dmaif_wr_req_pd,
  input  logic                   dmaif_wr_req_pvld,
  output logic                   dmaif_wr_req_prdy,
  output logic                   dmaif_wr_rsp_complete,
  output logic [NUM_IF*PD_W-1:0] if_wr_req_pd,
  output logic [NUM_IF-1:0]      if_wr_req_valid,
  input  logic [NUM_IF-1:0]      if_wr_req_ready,
  input  logic [NUM_IF-1:0]      if_wr_rsp_complete,
  output logic [CNT_W-1:0]       ack_outstanding
`ifdef NVDLA_DMAIF_WR_ERR_CHK_EN
  ,
  output logic                   dmaif_wr_err
`endif
);

  localparam int PTR_W = clog2(ACK_DEPTH);
  localparam int SEL_N = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_DEPTH);

  logic              w_sel_ok, w_need_ack, w_ack_room, w_accept, w_push;
  logic              w_head_hit, w_release;
  logic [SEL_N-1:0]  w_rdy_pad;
  logic [NUM_IF-1:0] w_skid_rdy, w_push_if, w_cmp_used, w_pend_used, w_pop_if;
  logic [SEL_W-1:0]  w_head;

  logic [SEL_W-1:0]  r_fifo [ACK_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_pend [NUM_IF];
  logic [NUM_IF-1:0] r_cmp;
  logic              r_rsp;

  assign w_sel_ok   = (int'(reg2dp_dst_ram_type) < NUM_IF);
  assign w_need_ack = !dmaif_wr_req_pd[PD_W-1] & dmaif_wr_req_pd[ACK_BIT];
  assign w_ack_room = (r_count < CNT_MAX) | w_release;

  // Padded so an out-of-range select indexes a zero instead of a missing bit.
  always_comb begin
    w_rdy_pad = '0;
    for (int k = 0; k < NUM_IF; k++) w_rdy_pad[k] = w_skid_rdy[k];
  end

  assign dmaif_wr_req_prdy = w_sel_ok & w_rdy_pad[reg2dp_dst_ram_type] &
                             (!w_need_ack | w_ack_room);
  assign w_accept = dmaif_wr_req_pvld & dmaif_wr_req_prdy;
  assign w_push   = w_accept & w_need_ack;
  assign w_head   = r_fifo[r_rd_ptr];

  // A fresh completion at the head is consumed before any banked one.
  always_comb begin
    w_head_hit  = 1'b0;
    w_cmp_used  = '0;
    w_pend_used = '0;
    w_pop_if    = '0;
    for (int k = 0; k < NUM_IF; k++) begin
      if (w_head == SEL_W'(k)) w_head_hit = r_cmp[k] | (r_pend[k] != '0);
    end
    w_release = (r_count != '0) & w_head_hit;
    for (int k = 0; k < NUM_IF; k++) begin
      w_pop_if[k]    = w_release & (w_head == SEL_W'(k));
      w_cmp_used[k]  = w_pop_if[k] & r_cmp[k];
      w_pend_used[k] = w_pop_if[k] & !r_cmp[k];
    end
  end

  for (genvar k = 0; k < NUM_IF; k++) begin : g_if
    assign w_push_if[k] = w_accept & (reg2dp_dst_ram_type == SEL_W'(k));
    nvdla_dmaif_skid2 #(.W(PD_W)) u_skid (
      .i_clk   (nvdla_core_clk),
      .i_rstn  (nvdla_core_rstn),
      .i_valid (w_push_if[k]),
      .o_ready (w_skid_rdy[k]),
      .i_data  (dmaif_wr_req_pd),
      .o_valid (if_wr_req_valid[k]),
      .i_ready (if_wr_req_ready[k]),
      .o_data  (if_wr_req_pd[k*PD_W +: PD_W])
    );
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_cmp    <= '0;
      r_rsp    <= 1'b0;
    end else begin
      r_cmp <= if_wr_rsp_complete;
      r_rsp <= w_release;
      if (w_push)    r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_release) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_release})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= reg2dp_dst_ram_type;
  end

  // Banked completions saturate; one arriving at the limit is dropped.
  always_ff @(posedge nvdla_core_clk) begin
    for (int k = 0; k < NUM_IF; k++) begin
      if (!nvdla_core_rstn) begin
        r_pend[k] <= '0;
      end else if (r_cmp[k] && !w_cmp_used[k]) begin
        if (r_pend[k] != CNT_MAX) r_pend[k] <= r_pend[k] + 1'b1;
      end else if (w_pend_used[k]) begin
        r_pend[k] <= r_pend[k] - 1'b1;
      end
    end
  end

`ifdef NVDLA_DMAIF_WR_ERR_CHK_EN
  logic [CNT_W-1:0] r_tag [NUM_IF];
  logic             r_err;

  // A bank that would reach or pass its tagged-entry count is unexpected.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_err <= 1'b0;
      for (int k = 0; k < NUM_IF; k++) r_tag[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_IF; k++) begin
        case ({w_push & w_push_if[k], w_pop_if[k]})
          2'b10:   r_tag[k] <= r_tag[k] + 1'b1;
          2'b01:   r_tag[k] <= r_tag[k] - 1'b1;
          default: r_tag[k] <= r_tag[k];
        endcase
        if (r_cmp[k] && !w_cmp_used[k] && (r_pend[k] >= r_tag[k])) r_err <= 1'b1;
      end
    end
  end

  assign dmaif_wr_err = r_err;
`endif

  assign dmaif_wr_rsp_complete = r_rsp;
  assign ack_outstanding       = r_count;

endmodule

// File: tb/tb_nvdla_dmaif_wr_nport.sv
// Directed bench for nvdla_dmaif_wr_nport: routing, in-order acks, FIFO full,
// backpressure, bad select (3-port instance) and mid-operation reset.
module tb_nvdla_dmaif_wr_nport;

  localparam int PD_W = 515;
  localparam int NIF  = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [0:0]          sel;
  logic [PD_W-1:0]     pd;
  logic                pvld;
  logic                prdy;
  logic                rsp;
  logic [NIF*PD_W-1:0] if_pd;
  logic [NIF-1:0]      if_valid;
  logic [NIF-1:0]      if_ready;
  logic [NIF-1:0]      if_cmp;
  logic [3:0]          ack_out;

  logic [1:0]          sel3;
  logic [PD_W-1:0]     pd3;
  logic                pvld3;
  logic                prdy3;
  logic                rsp3;
  logic [3*PD_W-1:0]   if_pd3;
  logic [2:0]          if_valid3;
  logic [2:0]          if_ready3;
  logic [2:0]          if_cmp3;
  logic [3:0]          ack3;
`ifdef NVDLA_DMAIF_WR_ERR_CHK_EN
  logic                err;
  logic                err3;
`endif

  nvdla_dmaif_wr_nport dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rstn       (rstn),
    .reg2dp_dst_ram_type   (sel),
    .dmaif_wr_req_pd       (pd),
    .dmaif_wr_req_pvld     (pvld),
    .dmaif_wr_req_prdy     (prdy),
    .dmaif_wr_rsp_complete (rsp),
    .if_wr_req_pd          (if_pd),
    .if_wr_req_valid       (if_valid),
    .if_wr_req_ready       (if_ready),
    .if_wr_rsp_complete    (if_cmp),
    .ack_outstanding       (ack_out)
`ifdef NVDLA_DMAIF_WR_ERR_CHK_EN
    ,
    .dmaif_wr_err          (err)
`endif
  );

  nvdla_dmaif_wr_nport #(.NUM_IF(3)) dut3 (
    .nvdla_core_clk        (clk),
    .nvdla_core_rstn       (rstn),
    .reg2dp_dst_ram_type   (sel3),
    .dmaif_wr_req_pd       (pd3),
    .dmaif_wr_req_pvld     (pvld3),
    .dmaif_wr_req_prdy     (prdy3),
    .dmaif_wr_rsp_complete (rsp3),
    .if_wr_req_pd          (if_pd3),
    .if_wr_req_valid       (if_valid3),
    .if_wr_req_ready       (if_ready3),
    .if_wr_rsp_complete    (if_cmp3),
    .ack_outstanding       (ack3)
`ifdef NVDLA_DMAIF_WR_ERR_CHK_EN
    ,
    .dmaif_wr_err          (err3)
`endif
  );

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  logic [PD_W-1:0] exp_q[$];
  logic [PD_W-1:0] obs_q0[$];
  logic [PD_W-1:0] obs_q1[$];
  int obs1_cyc[$];
  int out_cyc[$];
  int exp_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rstn) begin
      if (if_valid[0] && if_ready[0]) obs_q0.push_back(if_pd[PD_W-1:0]);
      if (if_valid[1] && if_ready[1]) begin
        obs_q1.push_back(if_pd[2*PD_W-1:PD_W]);
        obs1_cyc.push_back(cyc);
      end
    end
    if (rsp) out_cyc.push_back(cyc);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [PD_W-1:0] mk(input logic is_data, input logic ack, input logic [15:0] tag);
    logic [PD_W-1:0] p;
    p = '0;
    p[PD_W-1]  = is_data;
    p[77]      = ack;
    p[15:0]    = tag;
    p[300 +: 16] = ~tag;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic send_beat(input logic [PD_W-1:0] p);
    int n;
    n = 0;
    pd = p;
    pvld = 1'b1;
    #1;
    while (!prdy && n < 50) begin
      tick();
      n++;
    end
    if (!prdy) begin
      vecs++; errs++;
      $display("FAIL send_beat: prdy stuck at %b after %0d cycles, need 1", prdy, n);
    end
    tick();
    pvld = 1'b0;
  endtask

  task automatic pulse_cmp(input int k);
    if_cmp[k] = 1'b1;
    tick();
    if_cmp[k] = 1'b0;
  endtask

  task automatic clear_queues();
    exp_q.delete(); obs_q0.delete(); obs_q1.delete();
    obs1_cyc.delete(); out_cyc.delete(); exp_cyc.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0; pvld = 1'b0; pvld3 = 1'b0; sel = '0; sel3 = '0;
    pd = '0; pd3 = '0; if_ready = 2'b11; if_cmp = '0;
    if_ready3 = 3'b111; if_cmp3 = '0;
    wait_cycles(3);
    vecs++; if (if_valid !== 2'b00) begin errs++; $display("FAIL reset_valid: got %b need 00", if_valid); end
    vecs++; if (rsp !== 1'b0) begin errs++; $display("FAIL reset_rsp: got %b need 0", rsp); end
    vecs++; if (ack_out !== 4'd0) begin errs++; $display("FAIL reset_ack: got %0d need 0", ack_out); end
    rstn = 1'b1;
    tick();
    pd = mk(1'b1, 1'b0, 16'h0);
    #1;
    vecs++; if (prdy !== 1'b1) begin errs++; $display("FAIL reset_prdy_no_pvld: got %b need 1", prdy); end
  endtask

  task automatic test_stream();
    logic [PD_W-1:0] p;
    clear_queues();
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p = mk(1'b0, 1'b1, 16'(16'h100 + 3*i));
      exp_q.push_back(p);
      send_beat(p);
      for (int j = 0; j < 2; j++) begin
        p = mk(1'b1, 1'b0, 16'(16'h101 + 3*i + j));
        exp_q.push_back(p);
        send_beat(p);
      end
    end
    wait_cycles(4);
    vecs++; if (obs_q0.size() != 0) begin errs++; $display("FAIL stream_if0_count: got %0d need 0", obs_q0.size()); end
    vecs++; if (obs_q1.size() != 12) begin errs++; $display("FAIL stream_if1_count: got %0d need 12", obs_q1.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vecs++;
      if (i >= obs_q1.size() || obs_q1[i] !== exp_q[i]) begin
        errs++; $display("FAIL stream_beat%0d: got tag %h need tag %h", i, (i < obs_q1.size()) ? obs_q1[i][15:0] : 16'hxxxx, exp_q[i][15:0]);
      end
    end
    vecs++; if (ack_out !== 4'd4) begin errs++; $display("FAIL stream_ack_out: got %0d need 4", ack_out); end
    out_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      exp_cyc.push_back(cyc + 2);
      pulse_cmp(1);
      tick();
    end
    wait_cycles(4);
    vecs++; if (out_cyc.size() != 4) begin errs++; $display("FAIL stream_rsp_count: got %0d need 4", out_cyc.size()); end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (i >= out_cyc.size() || out_cyc[i] != exp_cyc[i]) begin
        errs++; $display("FAIL stream_rsp_cycle%0d: got %0d need %0d", i, (i < out_cyc.size()) ? out_cyc[i] : -1, exp_cyc[i]);
      end
    end
    vecs++; if (ack_out !== 4'd0) begin errs++; $display("FAIL stream_ack_drain: got %0d need 0", ack_out); end
  endtask

  task automatic test_out_of_order();
    int t;
    clear_queues();
    sel = 1'b0; send_beat(mk(1'b0, 1'b1, 16'h200));
    sel = 1'b1; send_beat(mk(1'b0, 1'b1, 16'h201));
    wait_cycles(3);
    out_cyc.delete();
    pulse_cmp(1);
    wait_cycles(4);
    vecs++; if (out_cyc.size() != 0) begin errs++; $display("FAIL ooo_early_rsp: got %0d pulses need 0", out_cyc.size()); end
    vecs++; if (ack_out !== 4'd2) begin errs++; $display("FAIL ooo_ack_hold: got %0d need 2", ack_out); end
    t = cyc;
    pulse_cmp(0);
    wait_cycles(5);
    vecs++; if (out_cyc.size() != 2) begin errs++; $display("FAIL ooo_rsp_count: got %0d need 2", out_cyc.size()); end
    vecs++; if (out_cyc.size() < 1 || out_cyc[0] != t + 2) begin errs++; $display("FAIL ooo_rsp0_cycle: got %0d need %0d", (out_cyc.size() > 0) ? out_cyc[0] : -1, t + 2); end
    vecs++; if (out_cyc.size() < 2 || out_cyc[1] != t + 3) begin errs++; $display("FAIL ooo_rsp1_cycle: got %0d need %0d", (out_cyc.size() > 1) ? out_cyc[1] : -1, t + 3); end
    vecs++; if (ack_out !== 4'd0) begin errs++; $display("FAIL ooo_ack_empty: got %0d need 0", ack_out); end
  endtask

  task automatic test_fifo_full();
    clear_queues();
    sel = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(mk(1'b0, 1'b1, 16'(16'h300 + i)));
    wait_cycles(2);
    vecs++; if (ack_out !== 4'd8) begin errs++; $display("FAIL full_ack_out: got %0d need 8", ack_out); end
    pvld = 1'b1;
    pd = mk(1'b0, 1'b1, 16'h309);
    #1;
    vecs++; if (prdy !== 1'b0) begin errs++; $display("FAIL full_ack_cmd_prdy: got %b need 0", prdy); end
    pd = mk(1'b1, 1'b0, 16'h30a);
    #1;
    vecs++; if (prdy !== 1'b1) begin errs++; $display("FAIL full_data_prdy: got %b need 1", prdy); end
    tick();
    pvld = 1'b0;
    out_cyc.delete();
    pulse_cmp(0);
    pd = mk(1'b0, 1'b1, 16'h309);
    pvld = 1'b1;
    #1;
    vecs++; if (prdy !== 1'b1) begin errs++; $display("FAIL full_pop_push_prdy: got %b need 1", prdy); end
    tick();
    pvld = 1'b0;
    vecs++; if (ack_out !== 4'd8) begin errs++; $display("FAIL full_pop_push_count: got %0d need 8", ack_out); end
    for (int i = 0; i < 8; i++) begin
      pulse_cmp(0);
      tick();
    end
    wait_cycles(4);
    vecs++; if (ack_out !== 4'd0) begin errs++; $display("FAIL full_drain_ack: got %0d need 0", ack_out); end
    vecs++; if (out_cyc.size() != 9) begin errs++; $display("FAIL full_drain_rsp: got %0d need 9", out_cyc.size()); end
  endtask

  task automatic test_backpressure();
    int i;
    clear_queues();
    sel = 1'b1;
    if_ready[1] = 1'b0;
    for (int k = 0; k < 6; k++) exp_q.push_back(mk(1'b1, 1'b0, 16'(16'h400 + k)));
    i = 0;
    pvld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      pd = exp_q[i];
      #1;
      if (prdy) i++;
      tick();
    end
    vecs++; if (i != 2) begin errs++; $display("FAIL bp_accepted: got %0d need 2", i); end
    pd = exp_q[i];
    #1;
    vecs++; if (prdy !== 1'b0) begin errs++; $display("FAIL bp_prdy_stall: got %b need 0", prdy); end
    if_ready[1] = 1'b1;
    for (int c = 0; c < 20 && i < 6; c++) begin
      pd = exp_q[i];
      #1;
      if (prdy) i++;
      tick();
    end
    pvld = 1'b0;
    vecs++; if (i != 6) begin errs++; $display("FAIL bp_all_sent: got %0d need 6", i); end
    wait_cycles(4);
    vecs++; if (obs_q1.size() != 6) begin errs++; $display("FAIL bp_beat_count: got %0d need 6", obs_q1.size()); end
    for (int k = 0; k < 6; k++) begin
      vecs++;
      if (k >= obs_q1.size() || obs_q1[k] !== exp_q[k]) begin
        errs++; $display("FAIL bp_beat%0d: got tag %h need tag %h", k, (k < obs_q1.size()) ? obs_q1[k][15:0] : 16'hxxxx, exp_q[k][15:0]);
      end
    end
    vecs++;
    if (obs1_cyc.size() != 6 || obs1_cyc[5] - obs1_cyc[0] != 5) begin
      errs++; $display("FAIL bp_throughput: got span %0d need 5", (obs1_cyc.size() == 6) ? obs1_cyc[5] - obs1_cyc[0] : -1);
    end
  endtask

  task automatic test_bad_sel();
    sel3 = 2'd3;
    pd3 = mk(1'b1, 1'b0, 16'h500);
    pvld3 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      vecs++; if (prdy3 !== 1'b0) begin errs++; $display("FAIL badsel_prdy c%0d: got %b need 0", c, prdy3); end
      vecs++; if (if_valid3 !== 3'b000) begin errs++; $display("FAIL badsel_valid c%0d: got %b need 000", c, if_valid3); end
      tick();
    end
    sel3 = 2'd2;
    #1;
    vecs++; if (prdy3 !== 1'b1) begin errs++; $display("FAIL goodsel_prdy: got %b need 1", prdy3); end
    tick();
    pvld3 = 1'b0;
    #1;
    vecs++; if (if_valid3 !== 3'b100) begin errs++; $display("FAIL goodsel_valid: got %b need 100", if_valid3); end
    wait_cycles(2);
  endtask

  task automatic test_reset_mid();
    clear_queues();
    sel = 1'b1; send_beat(mk(1'b0, 1'b1, 16'h600));
    sel = 1'b0; send_beat(mk(1'b0, 1'b1, 16'h601));
    send_beat(mk(1'b0, 1'b1, 16'h602));
    wait_cycles(3);
    vecs++; if (ack_out !== 4'd3) begin errs++; $display("FAIL rst_pre_ack: got %0d need 3", ack_out); end
    pulse_cmp(0); tick();
    pulse_cmp(0); tick();
    wait_cycles(3);
    vecs++; if (out_cyc.size() != 0) begin errs++; $display("FAIL rst_pre_rsp: got %0d need 0", out_cyc.size()); end
    if_ready[1] = 1'b0;
    sel = 1'b1;
    send_beat(mk(1'b1, 1'b0, 16'h603));
    vecs++; if (if_valid[1] !== 1'b1) begin errs++; $display("FAIL rst_pre_valid: got %b need 1", if_valid[1]); end
    rstn = 1'b0;
    tick();
    vecs++; if (if_valid !== 2'b00) begin errs++; $display("FAIL rst_mid_valid: got %b need 00", if_valid); end
    vecs++; if (ack_out !== 4'd0) begin errs++; $display("FAIL rst_mid_ack: got %0d need 0", ack_out); end
    rstn = 1'b1;
    if_ready = 2'b11;
    out_cyc.delete();
    wait_cycles(10);
    vecs++; if (out_cyc.size() != 0) begin errs++; $display("FAIL rst_post_rsp: got %0d need 0", out_cyc.size()); end
    vecs++; if (ack_out !== 4'd0) begin errs++; $display("FAIL rst_post_ack: got %0d need 0", ack_out); end
`ifdef NVDLA_DMAIF_WR_ERR_CHK_EN
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL err_clear: got %b need 0", err); end
    pulse_cmp(0);
    wait_cycles(3);
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_spurious: got %b need 1", err); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_out_of_order();
    test_fifo_full();
    test_backpressure();
    test_bad_sel();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
